// File: rtl/encoded_data_slicer_pkg.sv
// encoded_data_slicer_pkg: shared sizes, code-rate encodings and FSM state type for the slicer
package encoded_data_slicer_pkg;
  localparam int DATA_WIDTH   = 960;
  localparam int SYMBOL_NUM   = 160;
  localparam int SLICED_WIDTH = 6;
  localparam int IDX_WIDTH    = 8;
  localparam int PTR_WIDTH    = 10;
  localparam int STEP_R2      = 4;
  localparam int STEP_R3      = 6;
  localparam logic CODE_RATE_2 = 1'b0;
  localparam logic CODE_RATE_3 = 1'b1;
  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
endpackage

// File: rtl/encoded_data_slicer_symbol_extract.sv
// encoded_data_slicer_symbol_extract: picks the symbol whose first bit sits at ptr in the frame
module encoded_data_slicer_symbol_extract
  import encoded_data_slicer_pkg::*;
(
  input  logic [DATA_WIDTH-1:0]   frame,
  input  logic [PTR_WIDTH-1:0]    ptr,
  input  logic                    rate,
  output logic [SLICED_WIDTH-1:0] sym
);
  logic [DATA_WIDTH-1:0] aligned;
  // left-align bit ptr at the MSB so the symbol is always a fixed slice
  assign aligned = frame << (PTR_WIDTH'(DATA_WIDTH - 1) - ptr);
  assign sym = rate == CODE_RATE_3 ? aligned[DATA_WIDTH-1 -: 6] : {2'b00, aligned[DATA_WIDTH-1 -: 4]};
endmodule

// File: rtl/encoded_data_slicer.sv
// encoded_data_slicer: captures an encoded frame and streams it as one symbol per accepted beat
module encoded_data_slicer
  import encoded_data_slicer_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en_s,
  input  logic                    i_code_rate,
  input  logic [DATA_WIDTH-1:0]   i_encoder_data,
  input  logic                    i_encoder_done,
  input  logic                    i_ready,
  output logic [SLICED_WIDTH-1:0] o_sliced_data,
  output logic                    o_valid,
  output logic                    o_last,
  output logic [IDX_WIDTH-1:0]    o_symbol_idx,
  output logic                    o_slicer_done
);
  localparam logic [PTR_WIDTH-1:0] TOP = PTR_WIDTH'(DATA_WIDTH - 1);
  state_t state, state_n;
  logic [DATA_WIDTH-1:0] frame;
  logic rate_q;
  logic [PTR_WIDTH-1:0] ptr, ptr_n, step;
  logic [SLICED_WIDTH-1:0] sym;
  logic capture, prime, accept, adv, load_sym;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  always_comb begin
    state_n = !en_s ? state :
              state == IDLE && i_encoder_done ? LOAD :
              state == LOAD ? STREAM :
              state == STREAM && o_valid && i_ready && o_last ? DONE : state;
  end
  always_comb begin
    capture  = en_s && state == IDLE && i_encoder_done;
    prime    = en_s && state == STREAM && !o_valid;
    accept   = en_s && state == STREAM && o_valid && i_ready;
    adv      = accept && !o_last;
    step     = rate_q == CODE_RATE_3 ? PTR_WIDTH'(STEP_R3) : PTR_WIDTH'(STEP_R2);
    ptr_n    = adv ? ptr - step : ptr;
    load_sym = prime || adv;
  end
  encoded_data_slicer_symbol_extract u_extract (
    .frame (frame),
    .ptr   (ptr_n),
    .rate  (rate_q),
    .sym   (sym)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      frame         <= '0;
      rate_q        <= CODE_RATE_2;
      ptr           <= TOP;
      o_sliced_data <= '0;
      o_valid       <= 1'b0;
      o_last        <= 1'b0;
      o_symbol_idx  <= '0;
      o_slicer_done <= 1'b0;
    end else begin
      if (capture) begin
        frame        <= i_encoder_data;
        rate_q       <= i_code_rate;
        ptr          <= TOP;
        o_symbol_idx <= '0;
      end
      if (load_sym) o_sliced_data <= sym;
      if (prime) o_valid <= 1'b1;
      if (adv) begin
        ptr          <= ptr_n;
        o_symbol_idx <= o_symbol_idx + 1'b1;
      end
      if (accept) o_last <= !o_last && o_symbol_idx == IDX_WIDTH'(SYMBOL_NUM - 2);
      if (accept && o_last) begin
        o_valid       <= 1'b0;
        o_slicer_done <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_encoded_data_slicer.sv
// tb_encoded_data_slicer: directed vectors against a bench-side symbol model
module tb_encoded_data_slicer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en_s = 1'b1;
  logic i_code_rate = 1'b0;
  logic [959:0] i_encoder_data = '0;
  logic i_encoder_done = 1'b0;
  logic i_ready = 1'b1;
  logic [5:0] o_sliced_data;
  logic o_valid, o_last, o_slicer_done;
  logic [7:0] o_symbol_idx;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  encoded_data_slicer dut (
    .clk            (clk),
    .rst            (rst),
    .en_s           (en_s),
    .i_code_rate    (i_code_rate),
    .i_encoder_data (i_encoder_data),
    .i_encoder_done (i_encoder_done),
    .i_ready        (i_ready),
    .o_sliced_data  (o_sliced_data),
    .o_valid        (o_valid),
    .o_last         (o_last),
    .o_symbol_idx   (o_symbol_idx),
    .o_slicer_done  (o_slicer_done)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [959:0] mkframe(input int seed);
    logic [959:0] f;
    for (int i = 0; i < 960; i++) f[i] = ((i * seed + i / 7) % 3) == 0;
    return f;
  endfunction
  function automatic logic [5:0] model(input logic [959:0] f, input logic r, input int k);
    int p;
    logic [5:0] s;
    s = '0;
    p = 959 - k * (r ? 6 : 4);
    if (r) for (int j = 0; j < 6; j++) s[5-j] = f[p-j];
    else for (int j = 0; j < 4; j++) s[3-j] = f[p-j];
    return s;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    en_s = 1'b1;
    i_ready = 1'b1;
    i_encoder_done = 1'b0;
    tick();
    rst = 1'b0;
  endtask
  task automatic start(input logic [959:0] f, input logic r, input logic [5:0] first);
    i_encoder_data = f;
    i_code_rate = r;
    i_encoder_done = 1'b1;
    tick();
    i_encoder_done = 1'b0;
    chk("lat_n_valid", o_valid, 0);
    tick();
    chk("lat_n1_valid", o_valid, 0);
    tick();
    chk("lat_n2_valid", o_valid, 1);
    chk("first_idx", o_symbol_idx, 0);
    chk("first_data", o_sliced_data, first);
  endtask
  // mode: 0 plain, 1 backpressure, 2 rate flip + done re-pulse, 3 en_s pause, 4 reset at idx 80
  task automatic stream(input logic [959:0] f, input logic r, input int mode, input logic [5:0] last_exp);
    int k, cyc, pause;
    logic [3:0] pat;
    logic [5:0] last_d;
    k = 0;
    cyc = 0;
    pause = 0;
    pat = 4'b1001;
    last_d = '0;
    while (!o_slicer_done && cyc < 1000) begin
      chk("valid", o_valid, 1);
      chk("data", o_sliced_data, model(f, r, k));
      chk("idx", o_symbol_idx, k);
      chk("last", o_last, k == 159);
      if (k == 159) last_d = o_sliced_data;
      i_ready = mode == 1 ? pat[cyc % 4] : 1'b1;
      en_s = !(mode == 3 && k == 10 && pause < 5);
      if (!en_s) pause++;
      i_encoder_done = mode == 2 && k == 20;
      if (mode == 2 && k == 20) i_code_rate = ~r;
      rst = mode == 4 && k == 80;
      tick();
      if (rst) begin
        rst = 1'b0;
        chk("rst_data", o_sliced_data, 0);
        chk("rst_valid", o_valid, 0);
        chk("rst_last", o_last, 0);
        chk("rst_idx", o_symbol_idx, 0);
        chk("rst_done", o_slicer_done, 0);
        return;
      end
      if (en_s && i_ready) k++;
      cyc++;
    end
    i_encoder_done = 1'b0;
    en_s = 1'b1;
    i_ready = 1'b1;
    chk("beats", k, 160);
    chk("done", o_slicer_done, 1);
    chk("done_valid", o_valid, 0);
    chk("last_data", last_d, last_exp);
    tick();
    chk("done_sticky", o_slicer_done, 1);
  endtask
  initial begin
    logic [959:0] f2, f3, f2b, f3b;
    f2 = mkframe(5);
    f2[959:956] = 4'b1011;
    f2[323:320] = 4'b0110;
    f3 = mkframe(11);
    f3[959:954] = 6'b110001;
    f3[5:0] = 6'b010111;
    f2b = mkframe(3);
    f3b = mkframe(13);
    f3b[959:954] = 6'b011010;
    f3b[5:0] = 6'b100101;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_data", o_sliced_data, 0);
    chk("reset_valid", o_valid, 0);
    chk("reset_last", o_last, 0);
    chk("reset_idx", o_symbol_idx, 0);
    chk("reset_done", o_slicer_done, 0);
    rst = 1'b0;
    start(f2, 1'b0, 6'b001011);
    stream(f2, 1'b0, 0, 6'b000110);
    do_reset();
    start(f3, 1'b1, 6'b110001);
    stream(f3, 1'b1, 0, 6'b010111);
    do_reset();
    start(f2b, 1'b0, model(f2b, 1'b0, 0));
    stream(f2b, 1'b0, 1, model(f2b, 1'b0, 159));
    do_reset();
    start(f3, 1'b1, 6'b110001);
    stream(f3, 1'b1, 2, 6'b010111);
    do_reset();
    start(f3, 1'b1, 6'b110001);
    stream(f3, 1'b1, 3, 6'b010111);
    do_reset();
    start(f2, 1'b0, 6'b001011);
    stream(f2, 1'b0, 4, 6'b000110);
    start(f3b, 1'b1, 6'b011010);
    stream(f3b, 1'b1, 0, 6'b100101);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
